// File: rtl/simplecpu_pkg.sv
// simplecpu_pkg: shared encodings for the simpleCPU control units
package simplecpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        RTYPE,
        SHIFT,
        IMM,
        LUI,
        LOAD,
        STORE,
        BRANCH,
        JUMP,
        ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    localparam logic [1:0] ALUC_ADD = 2'b00;
    localparam logic [1:0] ALUC_SUB = 2'b01;
    localparam logic [1:0] ALUC_AND = 2'b10;
    localparam logic [1:0] ALUC_OR  = 2'b11;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [1:0] R2R_MEM = 2'b00;
    localparam logic [1:0] R2R_ALU = 2'b01;
    localparam logic [1:0] R2R_SH  = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: maps op/func to an instruction class and datapath steering controls
module ctrl_decode
    import simplecpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    iclass,
    output logic       Regrt,
    output logic       Se,
    output logic       Aluqb,
    output logic [1:0] Aluc,
    output logic [1:0] Reg2reg,
    output logic       Reglui,
    output logic       sArith,
    output logic       sRight
);

    // pure decode; steering holds in every FSM state so it depends only on op/func
    always_comb begin
        iclass  = ILLEGAL;
        Regrt   = 1'b0;
        Se      = 1'b0;
        Aluqb   = 1'b0;
        Aluc    = ALUC_ADD;
        Reg2reg = R2R_ALU;
        Reglui  = 1'b0;
        sArith  = 1'b0;
        sRight  = 1'b0;
        case (op)
            OP_RTYPE: begin
                Aluqb = 1'b1;
                case (func)
                    FN_ADD: iclass = RTYPE;
                    FN_SUB: begin
                        iclass = RTYPE;
                        Aluc   = ALUC_SUB;
                    end
                    FN_AND: begin
                        iclass = RTYPE;
                        Aluc   = ALUC_AND;
                    end
                    FN_OR: begin
                        iclass = RTYPE;
                        Aluc   = ALUC_OR;
                    end
                    FN_SLL: begin
                        iclass  = SHIFT;
                        Reg2reg = R2R_SH;
                    end
                    FN_SRL: begin
                        iclass  = SHIFT;
                        Reg2reg = R2R_SH;
                        sRight  = 1'b1;
                    end
                    FN_SRA: begin
                        iclass  = SHIFT;
                        Reg2reg = R2R_SH;
                        sRight  = 1'b1;
                        sArith  = 1'b1;
                    end
                    default: iclass = ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                iclass = IMM;
                Regrt  = 1'b1;
                Se     = 1'b1;
            end
            OP_ANDI: begin
                iclass = IMM;
                Regrt  = 1'b1;
                Aluc   = ALUC_AND;
            end
            OP_ORI: begin
                iclass = IMM;
                Regrt  = 1'b1;
                Aluc   = ALUC_OR;
            end
            OP_LUI: begin
                iclass = LUI;
                Regrt  = 1'b1;
                Reglui = 1'b1;
            end
            OP_LW: begin
                iclass  = LOAD;
                Regrt   = 1'b1;
                Se      = 1'b1;
                Reg2reg = R2R_MEM;
            end
            OP_SW: begin
                iclass = STORE;
                Se     = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                iclass = BRANCH;
                Se     = 1'b1;
                Aluqb  = 1'b1;
                Aluc   = ALUC_SUB;
            end
            OP_J: iclass = JUMP;
            default: iclass = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter
module multicycle_ctrl
    import simplecpu_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             pcrst,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    output logic             Irwr,
    output logic             Pcwr,
    output logic             Regrt,
    output logic             Se,
    output logic             Wreg,
    output logic             Aluqb,
    output logic [1:0]       Aluc,
    output logic             Wmem,
    output logic [1:0]       Pcsrc,
    output logic [1:0]       Reg2reg,
    output logic             Reglui,
    output logic             sArith,
    output logic             sRight,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t  cur, nxt;
    iclass_t iclass;
    logic    taken;

    ctrl_decode u_dec (
        .op      (op),
        .func    (func),
        .iclass  (iclass),
        .Regrt   (Regrt),
        .Se      (Se),
        .Aluqb   (Aluqb),
        .Aluc    (Aluc),
        .Reg2reg (Reg2reg),
        .Reglui  (Reglui),
        .sArith  (sArith),
        .sRight  (sRight)
    );

    assign taken  = (op == OP_BEQ) ? z : ~z;
    assign Pcsrc  = (iclass == JUMP) ? PCSRC_J : (iclass == BRANCH && taken) ? PCSRC_BR : PCSRC_SEQ;
    assign state  = cur;
    assign halted = (cur == S_HALT);

    // state register; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge pcrst) begin
        if (pcrst) cur <= S_FETCH;
        else       cur <= nxt;
    end

    // one count per completed instruction, marked by its single Pcwr
    always_ff @(posedge clk or posedge pcrst) begin
        if (pcrst)     retired <= '0;
        else if (Pcwr) retired <= retired + CNT_W'(1);
    end

    // next state and strobes; strobes are also held low while pcrst is high
    always_comb begin
        nxt  = cur;
        Irwr = 1'b0;
        Pcwr = 1'b0;
        Wreg = 1'b0;
        Wmem = 1'b0;
        if (!pcrst) begin
            case (cur)
                S_FETCH: begin
                    if (run) begin
                        Irwr = 1'b1;
                        nxt  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (iclass == JUMP) begin
                        Pcwr = 1'b1;
                        nxt  = S_FETCH;
                    end else if (iclass == ILLEGAL) begin
                        if (HALT_ON_ILLEGAL) nxt = S_HALT;
                        else begin
                            Pcwr = 1'b1;
                            nxt  = S_FETCH;
                        end
                    end else nxt = S_EXEC;
                end
                S_EXEC: begin
                    if (iclass == BRANCH) begin
                        Pcwr = 1'b1;
                        nxt  = S_FETCH;
                    end else if (iclass == LOAD || iclass == STORE) nxt = S_MEM;
                    else nxt = S_WB;
                end
                S_MEM: begin
                    if (iclass == STORE) begin
                        Wmem = 1'b1;
                        Pcwr = 1'b1;
                        nxt  = S_FETCH;
                    end else nxt = S_WB;
                end
                S_WB: begin
                    Wreg = 1'b1;
                    Pcwr = 1'b1;
                    nxt  = S_FETCH;
                end
                S_HALT: nxt = S_HALT;
                default: nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the simpleCPU datapath. It replaces the single-cycle control unit with a FETCH/DECODE/EXEC/MEM/WB state machine.
- Emits the existing datapath controls (Regrt, Se, Wreg, Aluqb, Aluc, Wmem, Pcsrc, Reg2reg, Reglui, sArith, sRight) plus PC and instruction-register write strobes. Each write is gated to exactly one cycle per instruction.
- Sits between the instruction register and the PC, register file, ALU, data memory and shifter. Also counts retired instructions and halts on an illegal opcode.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1, 1 = illegal op enters HALT; 0 = treat it as a 2-cycle NOP.

Ports:
- clk  in  1  system clock, rising edge.
- pcrst  in  1  reset, asynchronous, active-high.
- run  in  1  start/continue enable; sampled only in FETCH.
- op  in  6  inst[31:26] from the instruction register; stable from DECODE onward.
- func  in  6  inst[5:0] from the instruction register.
- z  in  1  ALU zero flag; sampled in EXEC.
- Irwr  out  1  instruction-register load strobe.
- Pcwr  out  1  PC write enable.
- Regrt, Se, Wreg, Aluqb, Wmem, Reglui, sArith, sRight  out  1 each  datapath controls, same meaning as the existing control unit.
- Aluc  out  2  00 add, 01 sub, 10 and, 11 or.
- Pcsrc  out  2  00 pc+4, 10 branch target, 11 jump target.
- Reg2reg  out  2  00 memory data, 01 ALU result, 10 shifter result.
- state  out  3  current state, for debug.
- halted  out  1  high while in HALT.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Interface: one clock (clk). Reset pcrst is asynchronous and active-high. On reset: state=FETCH, retired=0, halted=0, and all strobes (Irwr, Pcwr, Wreg, Wmem) are 0.
- States (3-bit encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Output style: Moore-style from the state register plus combinational decode of op/func. Steering outputs (Aluc, Aluqb, Reg2reg, etc.) hold their decoded value in every state. Only the strobes are state-gated.
- FETCH:
  - run=1: Irwr=1, then go to DECODE.
  - run=0: Irwr=0, stay in FETCH.
- DECODE:
  - j (000010): Pcwr=1 with Pcsrc=11, then FETCH (2 cycles total).
  - Illegal op: HALT if HALT_ON_ILLEGAL, else Pcwr=1 with Pcsrc=00, then FETCH.
  - Any other op: go to EXEC.
- EXEC:
  - beq (000100): Pcwr=1; Pcsrc=10 if z=1, else 00; then FETCH.
  - bne (000101): Pcwr=1; Pcsrc=10 if z=0, else 00; then FETCH.
  - lw (100011) or sw (101011): go to MEM.
  - Anything else: go to WB.
- MEM:
  - sw: Wmem=1, Pcwr=1 with Pcsrc=00, then FETCH (4 cycles).
  - lw: go to WB.
- WB: Wreg=1, Pcwr=1 with Pcsrc=00, then FETCH. Latency is 4 cycles for R-type, immediate and lui; 5 cycles for lw.
- Decode table:
  - R-type (op 000000):
    - add 100000: Aluc=00.
    - sub 100010: Aluc=01.
    - and 100100: Aluc=10.
    - or 100101: Aluc=11.
    - For all four: Regrt=0, Aluqb=1, Reg2reg=01.
    - sll 000000, srl 000010, sra 000011: Reg2reg=10; sRight=1 for srl/sra; sArith=1 for sra.
    - Any other func is illegal.
  - addi 001000: Se=1, Aluc=00.
  - andi 001100: Se=0, Aluc=10.
  - ori 001101: Se=0, Aluc=11.
  - For all three: Regrt=1, Aluqb=0, Reg2reg=01.
  - lui 001111: Regrt=1, Reglui=1.
  - lw/sw: Se=1, Aluqb=0, Aluc=00. lw also has Regrt=1, Reg2reg=00.
  - beq/bne: Aluqb=1, Aluc=01, Se=1.
- Strobe rules:
  - Wreg and Wmem are never asserted outside WB and MEM respectively.
  - Pcwr is asserted exactly once per instruction.
  - Irwr is asserted exactly once per instruction, and only in FETCH.
- retired: increments by 1 (mod 2^CNT_W) in every cycle where Pcwr=1; wraps from all-ones to 0 with no flag.
- HALT: all strobes 0, halted=1; exits only via pcrst. run is ignored.
- Reset mid-instruction: abandons the instruction immediately. No partial Wreg/Wmem occurs after pcrst rises.

Decomposition:
- Package simplecpu_pkg holds:
  - state encodings;
  - opcode and func constants;
  - Aluc/Pcsrc/Reg2reg codes;
  - instruction-class enum: RTYPE, SHIFT, IMM, LUI, LOAD, STORE, BRANCH, JUMP, ILLEGAL.
- Sub-module ctrl_decode: combinational mapping of op/func to class plus steering controls. It is reusable by the existing single-cycle unit. The FSM and counter stay in multicycle_ctrl.

Test Plan:
- Reset then run=1, add (op 0, func 100000) → Irwr in cycle 0; Wreg=1, Pcwr=1, Pcsrc=00, Reg2reg=01 in cycle 3; retired=1.
- lw then sw → lw: Wreg only in cycle 4, Reg2reg=00. sw: Wmem=1 only in cycle 3, Wreg never asserted; retired=2 after 9 cycles.
- beq with z=1 → Pcwr=1, Pcsrc=10 in cycle 2. beq with z=0 → Pcsrc=00. bne with z=0 → Pcsrc=10. Each branch is 3 cycles.
- j → Pcwr=1, Pcsrc=11 in cycle 1. Then sra (func 000011) → sRight=1, sArith=1, Reg2reg=10.
- op 111111 with HALT_ON_ILLEGAL=1 → HALT after DECODE, halted=1, no strobes for 20 cycles despite run=1. pcrst → FETCH, retired=0.
- pcrst pulsed during MEM of sw → Wmem drops asynchronously, state=FETCH. Separately, retired preloaded near all-ones wraps to 0 after two instructions.
